// File: rtl/alu_pkg.sv
// Shared definitions for the RV64 integer ALU: datapath width and the 4-bit
// operation codes used by the decoder and the ALU.
package alu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_ADDW = 4'b1010;
    localparam logic [3:0] ALU_SUBW = 4'b1011;
    localparam logic [3:0] ALU_SLLW = 4'b1100;
    localparam logic [3:0] ALU_SRLW = 4'b1101;
    localparam logic [3:0] ALU_SRAW = 4'b1110;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the ALU: left/right, logical/arithmetic,
// with a 32-bit word mode whose result is sign-extended from bit 31.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [5:0]      amount,
    input  logic            dir_right,
    input  logic            arith,
    input  logic            word,
    output logic [XLEN-1:0] result
);

    logic signed [XLEN-1:0] operand;
    logic signed [XLEN-1:0] shifted;
    logic [5:0]             amt;

    always_comb begin
        operand = data;
        amt     = amount;
        // Word mode pre-extends the low half so a 64-bit shift yields correct low 32 bits
        if (word) begin
            operand = arith ? {{(XLEN-32){data[31]}}, data[31:0]}
                            : {{(XLEN-32){1'b0}}, data[31:0]};
            amt     = {1'b0, amount[4:0]};
        end

        if (!dir_right) begin
            shifted = operand << amt;
        end else if (arith) begin
            shifted = operand >>> amt;
        end else begin
            shifted = operand >> amt;
        end

        result = word ? {{(XLEN-32){shifted[31]}}, shifted[31:0]} : shifted;
    end

endmodule

// File: rtl/alu.sv
// Registered RV64 integer ALU, one-cycle latency, result and zero flag.
// Optional W-suffix ops (ADDW/SUBW/SLLW/SRLW/SRAW) enabled by ALU_WORD_OPS_EN.
module alu #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic [3:0]      i_ALUctl,
    input  logic [XLEN-1:0] i_Rs1,
    input  logic [XLEN-1:0] i_Rs2,
    input  logic [XLEN-1:0] i_Immediate,
    input  logic            i_ALUsrc,
    output logic [XLEN-1:0] o_Result,
    output logic            o_Zero
);

    import alu_pkg::*;

    logic [XLEN-1:0]        op_a;
    logic [XLEN-1:0]        op_b;
    logic signed [XLEN-1:0] op_a_s;
    logic signed [XLEN-1:0] op_b_s;
    logic [XLEN-1:0]        sum;
    logic [XLEN-1:0]        diff;
    logic [XLEN-1:0]        shift_res;
    logic                   sh_right;
    logic                   sh_arith;
    logic                   sh_word;
    logic [XLEN-1:0]        result_p0;
    logic [XLEN-1:0]        result_p1;
    logic                   zero_p1;

    // Stage p0: operand select and combinational datapath
    assign op_a   = i_Rs1;
    assign op_b   = i_ALUsrc ? i_Immediate : i_Rs2;
    assign op_a_s = op_a;
    assign op_b_s = op_b;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;

`ifdef ALU_WORD_OPS_EN
    logic [31:0] addw;
    logic [31:0] subw;

    assign addw = op_a[31:0] + op_b[31:0];
    assign subw = op_a[31:0] - op_b[31:0];
`endif

    always_comb begin
        sh_right = 1'b0;
        sh_arith = 1'b0;
        sh_word  = 1'b0;
        case (i_ALUctl)
            ALU_SRL: sh_right = 1'b1;
            ALU_SRA: begin
                sh_right = 1'b1;
                sh_arith = 1'b1;
            end
`ifdef ALU_WORD_OPS_EN
            ALU_SLLW: sh_word = 1'b1;
            ALU_SRLW: begin
                sh_word  = 1'b1;
                sh_right = 1'b1;
            end
            ALU_SRAW: begin
                sh_word  = 1'b1;
                sh_right = 1'b1;
                sh_arith = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    alu_shifter u_shifter (
        .data      (op_a),
        .amount    (op_b[5:0]),
        .dir_right (sh_right),
        .arith     (sh_arith),
        .word      (sh_word),
        .result    (shift_res)
    );

    always_comb begin
        result_p0 = '0;
        case (i_ALUctl)
            ALU_AND:  result_p0 = op_a & op_b;
            ALU_OR:   result_p0 = op_a | op_b;
            ALU_ADD:  result_p0 = sum;
            ALU_XOR:  result_p0 = op_a ^ op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_p0 = shift_res;
            ALU_SUB:  result_p0 = diff;
            ALU_SLT:  result_p0 = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            ALU_SLTU: result_p0 = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_WORD_OPS_EN
            ALU_ADDW: result_p0 = {{(XLEN-32){addw[31]}}, addw};
            ALU_SUBW: result_p0 = {{(XLEN-32){subw[31]}}, subw};
            ALU_SLLW,
            ALU_SRLW,
            ALU_SRAW: result_p0 = shift_res;
`endif
            default:  result_p0 = '0;
        endcase
    end

    // Stage p1: output register; reset forces the zero-result state
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            result_p1 <= '0;
            zero_p1   <= 1'b1;
        end else begin
            result_p1 <= result_p0;
            zero_p1   <= (result_p0 == '0);
        end
    end

    assign o_Result = result_p1;
    assign o_Zero   = zero_p1;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered RV64 ALU.
module tb_alu;
    import alu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [3:0]      ctl;
    logic [63:0]     rs1;
    logic [63:0]     rs2;
    logic [63:0]     imm;
    logic            src;
    logic [63:0]     result;
    logic            zero;

    int checks   = 0;
    int failures = 0;

    alu dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_ALUctl    (ctl),
        .i_Rs1       (rs1),
        .i_Rs2       (rs2),
        .i_Immediate (imm),
        .i_ALUsrc    (src),
        .o_Result    (result),
        .o_Zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im, input logic s,
                          input logic [63:0] exp_res, input logic exp_zero);
        ctl = c;
        rs1 = a;
        rs2 = b;
        imm = im;
        src = s;
        @(posedge clk);
        #1;
        check_eq(tag, result, exp_res);
        check_eq({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_zero});
    endtask

    initial begin
        rst_n = 1'b0;
        ctl   = ALU_ADD;
        rs1   = 64'd0;
        rs2   = 64'd0;
        imm   = 64'd0;
        src   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_result", result, 64'd0);
        check_eq("reset_zero", {63'd0, zero}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_imm",     ALU_ADD, 64'd0, 64'd100, 64'd7, 1'b1, 64'd7, 1'b0);

        // Asynchronous reset between edges while ADD 5+7 is pending
        ctl = ALU_ADD; rs1 = 64'd5; rs2 = 64'd7; imm = 64'd99; src = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_result", result, 64'd0);
        check_eq("async_rst_zero", {63'd0, zero}, 64'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_add", result, 64'd12);

        run_op("add_rs2",     ALU_ADD, 64'd5, 64'd7, 64'd99, 1'b0, 64'd12, 1'b0);
        run_op("and",         ALU_AND, 64'hF, 64'hA, 64'd0, 1'b0, 64'hA, 1'b0);
        run_op("or",          ALU_OR,  64'hB, 64'h2, 64'd0, 1'b0, 64'hB, 1'b0);
        run_op("xor",         ALU_XOR, 64'hF0, 64'hFF, 64'd0, 1'b0, 64'h0F, 1'b0);
        run_op("sub_one",     ALU_SUB, 64'd6, 64'd5, 64'd0, 1'b0, 64'd1, 1'b0);
        run_op("sub_zero",    ALU_SUB, 64'd6, 64'd6, 64'd0, 1'b0, 64'd0, 1'b1);

        run_op("slt_neg",     ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0);
        run_op("sltu_big",    ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("add_wrap",    ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("slt_imm",     ALU_SLT,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1);
        run_op("sltu_imm",    ALU_SLTU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd1, 1'b0);

        run_op("sra",   ALU_SRA, 64'h8000_0000_0000_0000, 64'h41, 64'd0, 1'b0, 64'hC000_0000_0000_0000, 1'b0);
        run_op("srl",   ALU_SRL, 64'h8000_0000_0000_0000, 64'h41, 64'd0, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
        run_op("sll",   ALU_SLL, 64'h8000_0000_0000_0000, 64'h41, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("sll_by0", ALU_SLL, 64'h1234, 64'h40, 64'd0, 1'b0, 64'h1234, 1'b0);
        run_op("sll_by4", ALU_SLL, 64'h1234, 64'd4, 64'd0, 1'b0, 64'h12340, 1'b0);
        run_op("undef_1111", 4'b1111, 64'h8000_0000_0000_0000, 64'h41, 64'd0, 1'b0, 64'd0, 1'b1);

`ifdef ALU_WORD_OPS_EN
        run_op("addw", ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("subw", ALU_SUBW, 64'h1_0000_0000, 64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("sllw", ALU_SLLW, 64'd1, 64'd31, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("srlw", ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'h21, 64'd0, 1'b0, 64'h4000_0000, 1'b0);
        run_op("sraw", ALU_SRAW, 64'h8000_0000, 64'd4, 64'd0, 1'b0, 64'hFFFF_FFFF_F800_0000, 1'b0);
`else
        run_op("addw_off", ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("subw_off", ALU_SUBW, 64'h1_0000_0000, 64'd1, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("sllw_off", ALU_SLLW, 64'd1, 64'd31, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("srlw_off", ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'h21, 64'd0, 1'b0, 64'd0, 1'b1);
        run_op("sraw_off", ALU_SRAW, 64'h8000_0000, 64'd4, 64'd0, 1'b0, 64'd0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
